// File: rtl/megaduck_mapper_pkg.sv
// Shared types and decode constants for the MegaDuck-style successor mapper.
// Covers the ROM mode enum, CPU address decode fields and savestate bit positions.
package megaduck_mapper_pkg;

   typedef enum logic {
      MODE_UPPER = 1'b0,
      MODE_FULL  = 1'b1
   } mode_t;

   localparam logic [14:0] UPPER_REG_DEFAULT = 15'h0001;

   // cart_addr[14:13] selects the RAM-enable and RAM-bank windows with a15=0.
   localparam logic [1:0]  RAM_EN_SEL   = 2'b00;
   localparam logic [1:0]  RAM_BANK_SEL = 2'b10;

   // cart_addr[14:12] with a15=1 selects the 0xB000 full-window register.
   localparam logic [2:0]  FULL_SEL     = 3'b011;

   localparam int SS_BOTTOM_LSB   = 0;
   localparam int SS_TOP_LSB      = 12;
   localparam int SS_RAM_BANK_LSB = 24;
   localparam int SS_RAM_EN_BIT   = 28;
   localparam int SS_MODE_BIT     = 29;

endpackage

// File: rtl/mapper_bus_drive.sv
// Tri-state driver that puts a value on a shared mapper bus only while selected.
module mapper_bus_drive #(
   parameter int W = 8
) (
   input  logic         enable,
   input  logic [W-1:0] value,
   inout  wire  [W-1:0] bus
);

   assign bus = enable ? value : {W{1'bz}};

endmodule

// File: rtl/megaduck_mapper_gen.sv
// Parametrised MegaDuck-style mapper: UPPER/FULL ROM modes, banked cart RAM,
// savestate of all mapper state, and shared buses driven only while enabled.
module megaduck_mapper_gen
   import megaduck_mapper_pkg::*;
#(
   parameter int          ROM_BANK_W     = 8,
   parameter int          RAM_BANK_W     = 2,
   parameter logic [14:0] UPPER_REG_ADDR = UPPER_REG_DEFAULT,
   parameter bit          HAS_FULL_MODE  = 1'b1,
   parameter bit          HAS_BATTERY    = 1'b0
) (
   input  logic                  clk_sys,
   input  logic                  reset,
   input  logic                  enable,
   input  logic                  ce_cpu,
   input  logic                  savestate_load,
   input  logic [31:0]           savestate_data,
   inout  wire  [31:0]           savestate_back_b,
   input  logic                  has_ram,
   input  logic [3:0]            ram_mask,
   input  logic [ROM_BANK_W-1:0] rom_mask,
   input  logic [14:0]           cart_addr,
   input  logic                  cart_a15,
   input  logic                  cart_wr,
   input  logic [7:0]            cart_di,
   input  logic [7:0]            cram_di,
   inout  wire  [7:0]            cram_do_b,
   inout  wire  [16:0]           cram_addr_b,
   inout  wire  [22:0]           mbc_addr_b,
   inout  wire                   ram_enabled_b,
   inout  wire                   has_battery_b
);

   // A zero-width RAM bank still needs a 1-bit register; it is simply held at 0.
   localparam int RBW = (RAM_BANK_W > 0) ? RAM_BANK_W : 1;

   logic [ROM_BANK_W-1:0] bank_bottom;
   logic [ROM_BANK_W-1:0] bank_top;
   logic [RBW-1:0]        ram_bank;
   logic                  ram_en;
   mode_t                 mode;

   logic [11:0]           di_ext;
   logic                  wr_stb;
   logic [ROM_BANK_W-1:0] rom_bank;
   logic                  ram_enabled;
   logic [22:0]           mbc_addr;
   logic [16:0]           cram_addr;
   logic [7:0]            cram_do;
   logic                  has_battery;
   logic [31:0]           ss_image;
   logic                  unused_bits;

   assign di_ext = {4'h0, cart_di};
   assign wr_stb = ce_cpu & cart_wr;

   // Mapper state and mode FSM; deselecting the mapper behaves exactly like reset.
   always_ff @(posedge clk_sys) begin
      if (reset || !enable) begin
         bank_bottom <= '0;
         bank_top    <= {{(ROM_BANK_W-1){1'b0}}, 1'b1};
         ram_bank    <= '0;
         ram_en      <= 1'b0;
         mode        <= MODE_UPPER;
      end else if (savestate_load) begin
         bank_bottom <= savestate_data[SS_BOTTOM_LSB +: ROM_BANK_W];
         bank_top    <= savestate_data[SS_TOP_LSB +: ROM_BANK_W];
         ram_bank    <= (RAM_BANK_W > 0) ? savestate_data[SS_RAM_BANK_LSB +: RBW] : '0;
         ram_en      <= savestate_data[SS_RAM_EN_BIT];
         mode        <= mode_t'(savestate_data[SS_MODE_BIT]);
      end else if (wr_stb) begin
         if (!cart_a15) begin
            if (cart_addr == UPPER_REG_ADDR) begin
               bank_top <= (cart_di == 8'h00) ? {{(ROM_BANK_W-1){1'b0}}, 1'b1}
                                              : di_ext[ROM_BANK_W-1:0];
            end else if (cart_addr[14:13] == RAM_EN_SEL) begin
               ram_en <= has_ram & (cart_di[3:0] == 4'hA);
            end else if (cart_addr[14:13] == RAM_BANK_SEL && RAM_BANK_W > 0) begin
               ram_bank <= di_ext[RBW-1:0];
            end
         end else if (HAS_FULL_MODE && cart_addr[14:12] == FULL_SEL) begin
            bank_bottom <= {di_ext[ROM_BANK_W-2:0], 1'b0};
            bank_top    <= {di_ext[ROM_BANK_W-2:0], 1'b1};
            mode        <= MODE_FULL;
         end
      end
   end

   // Masking applies to both slots, so a masked top bank may legitimately map bank 0.
   always_comb begin
      rom_bank    = (cart_addr[14] ? bank_top : bank_bottom) & rom_mask;
      mbc_addr    = 23'({rom_bank, cart_addr[13:0]});
      cram_addr   = 17'({ram_bank & ram_mask[RBW-1:0], cart_addr[12:0]});
      ram_enabled = has_ram & ram_en;
      cram_do     = ram_enabled ? cram_di : 8'hFF;
      has_battery = HAS_BATTERY & has_ram;

      ss_image                                 = '0;
      ss_image[SS_BOTTOM_LSB +: ROM_BANK_W]    = bank_bottom;
      ss_image[SS_TOP_LSB +: ROM_BANK_W]       = bank_top;
      ss_image[SS_RAM_BANK_LSB +: RBW]         = ram_bank;
      ss_image[SS_RAM_EN_BIT]                  = ram_en;
      ss_image[SS_MODE_BIT]                    = mode;
   end

   assign unused_bits = ^{savestate_data, ram_mask, di_ext};

   mapper_bus_drive #(.W(32)) u_drive_ss (
      .enable (enable),
      .value  (ss_image),
      .bus    (savestate_back_b)
   );

   mapper_bus_drive #(.W(8)) u_drive_cram_do (
      .enable (enable),
      .value  (cram_do),
      .bus    (cram_do_b)
   );

   mapper_bus_drive #(.W(17)) u_drive_cram_addr (
      .enable (enable),
      .value  (cram_addr),
      .bus    (cram_addr_b)
   );

   mapper_bus_drive #(.W(23)) u_drive_mbc_addr (
      .enable (enable),
      .value  (mbc_addr),
      .bus    (mbc_addr_b)
   );

   mapper_bus_drive #(.W(1)) u_drive_ram_en (
      .enable (enable),
      .value  (ram_enabled),
      .bus    (ram_enabled_b)
   );

   mapper_bus_drive #(.W(1)) u_drive_battery (
      .enable (enable),
      .value  (has_battery),
      .bus    (has_battery_b)
   );

endmodule

// File: tb/tb_megaduck_mapper_gen.sv
// Directed self-checking bench for megaduck_mapper_gen with default parameters.
module tb_megaduck_mapper_gen;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        enable;
   logic        ce_cpu;
   logic        savestate_load;
   logic [31:0] savestate_data;
   logic        has_ram;
   logic [3:0]  ram_mask;
   logic [7:0]  rom_mask;
   logic [14:0] cart_addr;
   logic        cart_a15;
   logic        cart_wr;
   logic [7:0]  cart_di;
   logic [7:0]  cram_di;

   wire  [31:0] savestate_back_b;
   wire  [7:0]  cram_do_b;
   wire  [16:0] cram_addr_b;
   wire  [22:0] mbc_addr_b;
   wire         ram_enabled_b;
   wire         has_battery_b;

   pullup (ram_enabled_b);
   pullup (has_battery_b);

   int n_compared   = 0;
   int n_mismatched = 0;

   logic [31:0] saved_image;

   always #5 clk_sys = ~clk_sys;

   megaduck_mapper_gen dut (
      .clk_sys          (clk_sys),
      .reset            (reset),
      .enable           (enable),
      .ce_cpu           (ce_cpu),
      .savestate_load   (savestate_load),
      .savestate_data   (savestate_data),
      .savestate_back_b (savestate_back_b),
      .has_ram          (has_ram),
      .ram_mask         (ram_mask),
      .rom_mask         (rom_mask),
      .cart_addr        (cart_addr),
      .cart_a15         (cart_a15),
      .cart_wr          (cart_wr),
      .cart_di          (cart_di),
      .cram_di          (cram_di),
      .cram_do_b        (cram_do_b),
      .cram_addr_b      (cram_addr_b),
      .mbc_addr_b       (mbc_addr_b),
      .ram_enabled_b    (ram_enabled_b),
      .has_battery_b    (has_battery_b)
   );

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d, input logic ce);
      cart_a15  = a[15];
      cart_addr = a[14:0];
      cart_di   = d;
      cart_wr   = 1'b1;
      ce_cpu    = ce;
      @(posedge clk_sys);
      #1;
      cart_wr   = 1'b0;
      ce_cpu    = 1'b0;
   endtask

   task automatic set_addr(input logic [15:0] a);
      cart_a15  = a[15];
      cart_addr = a[14:0];
      #1;
   endtask

   task automatic test_reset();
      reset  = 1'b1;
      enable = 1'b1;
      repeat (2) @(posedge clk_sys);
      #1;
      reset = 1'b0;
      set_addr(16'h4000);
      n_compared++;
      if (mbc_addr_b !== 23'h004000) begin n_mismatched++; $display("[TB] FAIL reset_mbc_4000 got %h want 004000", mbc_addr_b); end
      set_addr(16'h0000);
      n_compared++;
      if (mbc_addr_b !== 23'h000000) begin n_mismatched++; $display("[TB] FAIL reset_mbc_0000 got %h want 000000", mbc_addr_b); end
      n_compared++;
      if (ram_enabled_b !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_ram_enabled got %b want 0", ram_enabled_b); end
      n_compared++;
      if (cram_do_b !== 8'hFF) begin n_mismatched++; $display("[TB] FAIL reset_cram_do got %h want FF", cram_do_b); end
      n_compared++;
      if (savestate_back_b !== 32'h0000_1000) begin n_mismatched++; $display("[TB] FAIL reset_image got %h want 00001000", savestate_back_b); end
      n_compared++;
      if (has_battery_b !== 1'b0) begin n_mismatched++; $display("[TB] FAIL reset_battery got %b want 0", has_battery_b); end
   endtask

   task automatic test_upper_bank();
      cpu_write(16'h0001, 8'h00, 1'b1);
      set_addr(16'h4123);
      n_compared++;
      if (mbc_addr_b !== 23'h004123) begin n_mismatched++; $display("[TB] FAIL upper_zero_forced got %h want 004123", mbc_addr_b); end
      cpu_write(16'h0001, 8'h05, 1'b1);
      set_addr(16'h4123);
      n_compared++;
      if (mbc_addr_b !== 23'h014123) begin n_mismatched++; $display("[TB] FAIL upper_bank5 got %h want 014123", mbc_addr_b); end
      set_addr(16'h0123);
      n_compared++;
      if (mbc_addr_b !== 23'h000123) begin n_mismatched++; $display("[TB] FAIL upper_bottom0 got %h want 000123", mbc_addr_b); end
      cpu_write(16'h0001, 8'h22, 1'b0);
      set_addr(16'h4123);
      n_compared++;
      if (mbc_addr_b !== 23'h014123) begin n_mismatched++; $display("[TB] FAIL upper_no_ce got %h want 014123", mbc_addr_b); end
   endtask

   task automatic test_full_mode();
      cpu_write(16'hB000, 8'h03, 1'b1);
      set_addr(16'h0000);
      n_compared++;
      if (mbc_addr_b !== 23'h018000) begin n_mismatched++; $display("[TB] FAIL full_bottom got %h want 018000", mbc_addr_b); end
      set_addr(16'h4000);
      n_compared++;
      if (mbc_addr_b !== 23'h01C000) begin n_mismatched++; $display("[TB] FAIL full_top got %h want 01C000", mbc_addr_b); end
      n_compared++;
      if (savestate_back_b !== 32'h2000_7006) begin n_mismatched++; $display("[TB] FAIL full_image got %h want 20007006", savestate_back_b); end
      cpu_write(16'h0001, 8'h09, 1'b1);
      set_addr(16'h4000);
      n_compared++;
      if (mbc_addr_b !== 23'h024000) begin n_mismatched++; $display("[TB] FAIL full_upper_write got %h want 024000", mbc_addr_b); end
      set_addr(16'h0000);
      n_compared++;
      if (mbc_addr_b !== 23'h018000) begin n_mismatched++; $display("[TB] FAIL full_bottom_kept got %h want 018000", mbc_addr_b); end
      cpu_write(16'hC000, 8'h55, 1'b1);
      #1;
      n_compared++;
      if (savestate_back_b !== 32'h2000_9006) begin n_mismatched++; $display("[TB] FAIL full_sticky_ignored got %h want 20009006", savestate_back_b); end
   endtask

   task automatic test_cart_ram();
      has_ram = 1'b0;
      cpu_write(16'h0000, 8'h0A, 1'b1);
      #1;
      n_compared++;
      if (ram_enabled_b !== 1'b0) begin n_mismatched++; $display("[TB] FAIL ram_no_ram got %b want 0", ram_enabled_b); end
      has_ram = 1'b1;
      cpu_write(16'h0000, 8'h0A, 1'b1);
      cpu_write(16'h4000, 8'h02, 1'b1);
      set_addr(16'hA010);
      n_compared++;
      if (ram_enabled_b !== 1'b1) begin n_mismatched++; $display("[TB] FAIL ram_enable got %b want 1", ram_enabled_b); end
      n_compared++;
      if (cram_addr_b !== 17'h04010) begin n_mismatched++; $display("[TB] FAIL ram_addr got %h want 04010", cram_addr_b); end
      n_compared++;
      if (cram_do_b !== 8'h5A) begin n_mismatched++; $display("[TB] FAIL ram_data got %h want 5A", cram_do_b); end
      ram_mask = 4'h1;
      #1;
      n_compared++;
      if (cram_addr_b !== 17'h00010) begin n_mismatched++; $display("[TB] FAIL ram_mask got %h want 00010", cram_addr_b); end
      ram_mask = 4'hF;
      cpu_write(16'h0000, 8'h00, 1'b1);
      #1;
      n_compared++;
      if (cram_do_b !== 8'hFF) begin n_mismatched++; $display("[TB] FAIL ram_disable got %h want FF", cram_do_b); end
   endtask

   task automatic test_mask_savestate();
      cpu_write(16'h0001, 8'h0D, 1'b1);
      rom_mask = 8'h07;
      set_addr(16'h4000);
      n_compared++;
      if (mbc_addr_b !== 23'h014000) begin n_mismatched++; $display("[TB] FAIL mask_top got %h want 014000", mbc_addr_b); end
      rom_mask = 8'h02;
      #1;
      n_compared++;
      if (mbc_addr_b !== 23'h000000) begin n_mismatched++; $display("[TB] FAIL mask_top_zero got %h want 000000", mbc_addr_b); end
      rom_mask = 8'hFF;
      saved_image = 32'h2200_D006;
      #1;
      n_compared++;
      if (savestate_back_b !== saved_image) begin n_mismatched++; $display("[TB] FAIL ss_image got %h want %h", savestate_back_b, saved_image); end
      reset = 1'b1;
      @(posedge clk_sys);
      #1;
      reset = 1'b0;
      savestate_data = saved_image;
      savestate_load = 1'b1;
      @(posedge clk_sys);
      #1;
      savestate_load = 1'b0;
      set_addr(16'h4000);
      n_compared++;
      if (mbc_addr_b !== 23'h034000) begin n_mismatched++; $display("[TB] FAIL ss_restore_top got %h want 034000", mbc_addr_b); end
      set_addr(16'hA010);
      n_compared++;
      if (cram_addr_b !== 17'h04010) begin n_mismatched++; $display("[TB] FAIL ss_restore_ram got %h want 04010", cram_addr_b); end
      n_compared++;
      if (savestate_back_b !== saved_image) begin n_mismatched++; $display("[TB] FAIL ss_restore_image got %h want %h", savestate_back_b, saved_image); end
      savestate_data = 32'h0000_0000;
      savestate_load = 1'b1;
      @(posedge clk_sys);
      #1;
      savestate_load = 1'b0;
      set_addr(16'h4000);
      n_compared++;
      if (mbc_addr_b !== 23'h000000) begin n_mismatched++; $display("[TB] FAIL ss_unfiltered_top0 got %h want 000000", mbc_addr_b); end
   endtask

   task automatic test_enable_and_priority();
      cpu_write(16'h0001, 8'h05, 1'b1);
      set_addr(16'h4000);
      n_compared++;
      if (mbc_addr_b !== 23'h014000) begin n_mismatched++; $display("[TB] FAIL en_pre got %h want 014000", mbc_addr_b); end
      enable = 1'b0;
      #1;
      n_compared++;
      if (ram_enabled_b !== 1'b1) begin n_mismatched++; $display("[TB] FAIL en_ram_bus_released got %b want pulled 1", ram_enabled_b); end
      n_compared++;
      if (has_battery_b !== 1'b1) begin n_mismatched++; $display("[TB] FAIL en_battery_bus_released got %b want pulled 1", has_battery_b); end
      cpu_write(16'h0001, 8'h09, 1'b1);
      enable = 1'b1;
      set_addr(16'h4000);
      n_compared++;
      if (mbc_addr_b !== 23'h004000) begin n_mismatched++; $display("[TB] FAIL en_state_reset got %h want 004000", mbc_addr_b); end
      n_compared++;
      if (savestate_back_b !== 32'h0000_1000) begin n_mismatched++; $display("[TB] FAIL en_image_reset got %h want 00001000", savestate_back_b); end
      savestate_data = 32'h0000_3000;
      savestate_load = 1'b1;
      cpu_write(16'h0001, 8'h05, 1'b1);
      savestate_load = 1'b0;
      set_addr(16'h4000);
      n_compared++;
      if (mbc_addr_b !== 23'h00C000) begin n_mismatched++; $display("[TB] FAIL load_beats_write got %h want 00C000", mbc_addr_b); end
      n_compared++;
      if (savestate_back_b !== 32'h0000_3000) begin n_mismatched++; $display("[TB] FAIL load_beats_write_image got %h want 00003000", savestate_back_b); end
   endtask

   initial begin
      reset          = 1'b1;
      enable         = 1'b0;
      ce_cpu         = 1'b0;
      savestate_load = 1'b0;
      savestate_data = 32'h0;
      has_ram        = 1'b0;
      ram_mask       = 4'hF;
      rom_mask       = 8'hFF;
      cart_addr      = 15'h0;
      cart_a15       = 1'b0;
      cart_wr        = 1'b0;
      cart_di        = 8'h00;
      cram_di        = 8'h5A;
      saved_image    = 32'h0;
      #1;
      test_reset();
      test_upper_bank();
      test_full_mode();
      test_cart_ram();
      test_mask_savestate();
      test_enable_and_priority();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
